// File: rtl/rv32_mod_mem_port_arbiter.sv
// rv32_mod_mem_port_arbiter
// Shares the single core memory port between instruction fetch and the
// load/store unit. One bus transaction is in flight at a time; the arbiter
// forms byte enables and replicated store lanes on the way out, and aligns
// and extends load data on the way back. Misaligned or illegal accesses are
// answered without a bus cycle; a bus that never acks can be timed out.
module rv32_mod_mem_port_arbiter #(
    parameter int PRIO_MODE      = 0,   // 0: LSU always wins, 1: round-robin
    parameter int TIMEOUT_CYCLES = 0    // 0: wait for mem_ack forever
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        lsu_req,
    input  logic        lsu_wr,
    input  logic [2:0]  lsu_func,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_ack,
    output logic [31:0] lsu_rdata,
    output logic        lsu_err,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam bit          RR_EN     = (PRIO_MODE != 0);
    localparam bit          TMO_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT_CYCLES);

    // True when an LSU access is an illegal width or is misaligned for its width.
    function automatic logic lsu_bad(input logic wr, input logic [2:0] func,
                                     input logic [1:0] off);
        logic illegal;
        logic misal;
        illegal = (func == 3'b011) || (func == 3'b110) || (func == 3'b111) ||
                  (wr && func[2]);
        misal   = ((func[1:0] == 2'b01) && off[0]) ||
                  ((func[1:0] == 2'b10) && (off != 2'b00));
        return illegal | misal;
    endfunction

    // Byte enables for an LSU access of the given width at byte offset off.
    function automatic logic [3:0] lsu_be(input logic [2:0] func, input logic [1:0] off);
        logic [3:0] be;
        case (func[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicates right-aligned store data into every lane it may land in.
    function automatic logic [31:0] store_lanes(input logic [2:0] func, input logic [31:0] w);
        logic [31:0] d;
        case (func[1:0])
            2'b00:   d = {4{w[7:0]}};
            2'b01:   d = {2{w[15:0]}};
            2'b10:   d = w;
            default: d = 32'd0;
        endcase
        return d;
    endfunction

    // Moves the addressed bytes down to bit 0 and applies the load width rule.
    function automatic logic [31:0] fmt_load(input logic [2:0] func, input logic [1:0] off,
                                             input logic [31:0] raw);
        logic [31:0] sh;
        logic [31:0] d;
        sh = raw >> {off, 3'b000};
        case (func)
            3'b000:  d = {{24{sh[7]}}, sh[7:0]};
            3'b001:  d = {{16{sh[15]}}, sh[15:0]};
            3'b010:  d = sh;
            3'b100:  d = {24'd0, sh[7:0]};
            3'b101:  d = {16'd0, sh[15:0]};
            default: d = 32'd0;
        endcase
        return d;
    endfunction

    state_e      state_q,     state_d;
    logic        last_lsu_q,  last_lsu_d;   // 0 = IF was granted last
    logic        owner_lsu_q, owner_lsu_d;
    logic        wr_q,        wr_d;
    logic [2:0]  func_q,      func_d;
    logic [1:0]  off_q,       off_d;
    logic [31:0] tmo_cnt_q,   tmo_cnt_d;
    logic        mem_req_q,   mem_req_d;
    logic        mem_wr_q,    mem_wr_d;
    logic [31:0] mem_addr_q,  mem_addr_d;
    logic [3:0]  mem_be_q,    mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        if_ack_q,    if_ack_d;
    logic [31:0] if_rdata_q,  if_rdata_d;
    logic        if_err_q,    if_err_d;
    logic        lsu_ack_q,   lsu_ack_d;
    logic [31:0] lsu_rdata_q, lsu_rdata_d;
    logic        lsu_err_q,   lsu_err_d;

    logic        req_any_s;
    logic        grant_lsu_s;
    logic        sel_wr_s;
    logic [2:0]  sel_func_s;
    logic [31:0] sel_addr_s;
    logic        sel_bad_s;
    logic [3:0]  sel_be_s;
    logic [31:0] sel_wdata_s;
    logic [31:0] tmo_cnt_inc_s;

    assign req_any_s     = if_req | lsu_req;
    assign tmo_cnt_inc_s = tmo_cnt_q + 32'd1;

    // Chooses the winner when both requesters are pending.
    always_comb begin
        if (if_req && lsu_req) begin
            grant_lsu_s = RR_EN ? ~last_lsu_q : 1'b1;
        end else begin
            grant_lsu_s = lsu_req;
        end
    end

    // Forms the bus fields and the legality check for the granted requester.
    always_comb begin
        if (grant_lsu_s) begin
            sel_wr_s    = lsu_wr;
            sel_func_s  = lsu_func;
            sel_addr_s  = lsu_addr;
            sel_bad_s   = lsu_bad(lsu_wr, lsu_func, lsu_addr[1:0]);
            sel_be_s    = lsu_be(lsu_func, lsu_addr[1:0]);
            sel_wdata_s = lsu_wr ? store_lanes(lsu_func, lsu_wdata) : 32'd0;
        end else begin
            sel_wr_s    = 1'b0;
            sel_func_s  = 3'b010;
            sel_addr_s  = if_addr;
            sel_bad_s   = |if_addr[1:0];
            sel_be_s    = 4'b1111;
            sel_wdata_s = 32'd0;
        end
    end

    // Next-state and registered-output logic of the IDLE/BUS/RESP sequencer.
    always_comb begin
        state_d     = state_q;
        last_lsu_d  = last_lsu_q;
        owner_lsu_d = owner_lsu_q;
        wr_d        = wr_q;
        func_d      = func_q;
        off_d       = off_q;
        tmo_cnt_d   = tmo_cnt_q;
        mem_req_d   = mem_req_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        if_ack_d    = 1'b0;
        if_rdata_d  = 32'd0;
        if_err_d    = 1'b0;
        lsu_ack_d   = 1'b0;
        lsu_rdata_d = 32'd0;
        lsu_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_any_s) begin
                    owner_lsu_d = grant_lsu_s;
                    wr_d        = sel_wr_s;
                    func_d      = sel_func_s;
                    off_d       = sel_addr_s[1:0];
                    if (sel_bad_s) begin
                        // Rejected up front: answer with an error, no bus cycle.
                        state_d   = ST_RESP;
                        if_ack_d  = ~grant_lsu_s;
                        if_err_d  = ~grant_lsu_s;
                        lsu_ack_d = grant_lsu_s;
                        lsu_err_d = grant_lsu_s;
                    end else begin
                        state_d     = ST_BUS;
                        tmo_cnt_d   = 32'd0;
                        mem_req_d   = 1'b1;
                        mem_wr_d    = sel_wr_s;
                        mem_addr_d  = {sel_addr_s[31:2], 2'b00};
                        mem_be_d    = sel_be_s;
                        mem_wdata_d = sel_wdata_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUS: begin
                if (mem_ack) begin
                    state_d   = ST_RESP;
                    mem_req_d = 1'b0;
                    if (owner_lsu_q) begin
                        lsu_ack_d   = 1'b1;
                        lsu_rdata_d = wr_q ? 32'd0 : fmt_load(func_q, off_q, mem_rdata);
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end else if (TMO_EN && (tmo_cnt_inc_s == TMO_LIMIT)) begin
                    // Bus gave up on: withdraw the request and report an error.
                    state_d   = ST_RESP;
                    tmo_cnt_d = tmo_cnt_inc_s;
                    mem_req_d = 1'b0;
                    if (owner_lsu_q) begin
                        lsu_ack_d = 1'b1;
                        lsu_err_d = 1'b1;
                    end else begin
                        if_ack_d = 1'b1;
                        if_err_d = 1'b1;
                    end
                end else begin
                    state_d   = ST_BUS;
                    tmo_cnt_d = tmo_cnt_inc_s;
                end
            end
            ST_RESP: begin
                state_d    = ST_IDLE;
                last_lsu_d = owner_lsu_q;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            last_lsu_q  <= 1'b0;
            owner_lsu_q <= 1'b0;
            wr_q        <= 1'b0;
            func_q      <= 3'd0;
            off_q       <= 2'd0;
            tmo_cnt_q   <= 32'd0;
            mem_req_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_be_q    <= 4'd0;
            mem_wdata_q <= 32'd0;
            if_ack_q    <= 1'b0;
            if_rdata_q  <= 32'd0;
            if_err_q    <= 1'b0;
            lsu_ack_q   <= 1'b0;
            lsu_rdata_q <= 32'd0;
            lsu_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_lsu_q  <= last_lsu_d;
            owner_lsu_q <= owner_lsu_d;
            wr_q        <= wr_d;
            func_q      <= func_d;
            off_q       <= off_d;
            tmo_cnt_q   <= tmo_cnt_d;
            mem_req_q   <= mem_req_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            if_rdata_q  <= if_rdata_d;
            if_err_q    <= if_err_d;
            lsu_ack_q   <= lsu_ack_d;
            lsu_rdata_q <= lsu_rdata_d;
            lsu_err_q   <= lsu_err_d;
        end
    end

    assign if_ack    = if_ack_q;
    assign if_rdata  = if_rdata_q;
    assign if_err    = if_err_q;
    assign lsu_ack   = lsu_ack_q;
    assign lsu_rdata = lsu_rdata_q;
    assign lsu_err   = lsu_err_q;
    assign mem_req   = mem_req_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_rv32_mod_mem_port_arbiter.sv
// Directed bench for rv32_mod_mem_port_arbiter. Instance A: fixed LSU
// priority with a 4-cycle timeout; instance B: round-robin, no timeout.
// Expected responses go into scoreboard queues when a request is driven and
// are popped when the matching ack appears.
module tb_rv32_mod_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    logic        a_if_req, a_if_ack, a_if_err, a_lsu_req, a_lsu_wr, a_lsu_ack, a_lsu_err;
    logic [31:0] a_if_addr, a_if_rdata, a_lsu_addr, a_lsu_wdata, a_lsu_rdata;
    logic [2:0]  a_lsu_func;
    logic        a_mem_req, a_mem_wr, a_mem_ack;
    logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic [3:0]  a_mem_be;
    logic        a_auto = 1'b0, a_auto_ack = 1'b0, a_late_ack = 1'b0;

    logic        b_if_req, b_if_ack, b_if_err, b_lsu_req, b_lsu_wr, b_lsu_ack, b_lsu_err;
    logic [31:0] b_if_addr, b_if_rdata, b_lsu_addr, b_lsu_wdata, b_lsu_rdata;
    logic [2:0]  b_lsu_func;
    logic        b_mem_req, b_mem_wr, b_mem_ack;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [3:0]  b_mem_be;
    logic        b_auto = 1'b0, b_auto_ack = 1'b0;

    assign a_mem_ack = a_auto_ack | a_late_ack;
    assign b_mem_ack = b_auto_ack;

    rv32_mod_mem_port_arbiter #(.PRIO_MODE(0), .TIMEOUT_CYCLES(4)) u_a (
        .clk(clk), .rst_n(rst_n),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_ack(a_if_ack),
        .if_rdata(a_if_rdata), .if_err(a_if_err),
        .lsu_req(a_lsu_req), .lsu_wr(a_lsu_wr), .lsu_func(a_lsu_func),
        .lsu_addr(a_lsu_addr), .lsu_wdata(a_lsu_wdata), .lsu_ack(a_lsu_ack),
        .lsu_rdata(a_lsu_rdata), .lsu_err(a_lsu_err),
        .mem_req(a_mem_req), .mem_wr(a_mem_wr), .mem_addr(a_mem_addr),
        .mem_be(a_mem_be), .mem_wdata(a_mem_wdata),
        .mem_ack(a_mem_ack), .mem_rdata(a_mem_rdata)
    );

    rv32_mod_mem_port_arbiter #(.PRIO_MODE(1), .TIMEOUT_CYCLES(0)) u_b (
        .clk(clk), .rst_n(rst_n),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_ack(b_if_ack),
        .if_rdata(b_if_rdata), .if_err(b_if_err),
        .lsu_req(b_lsu_req), .lsu_wr(b_lsu_wr), .lsu_func(b_lsu_func),
        .lsu_addr(b_lsu_addr), .lsu_wdata(b_lsu_wdata), .lsu_ack(b_lsu_ack),
        .lsu_rdata(b_lsu_rdata), .lsu_err(b_lsu_err),
        .mem_req(b_mem_req), .mem_wr(b_mem_wr), .mem_addr(b_mem_addr),
        .mem_be(b_mem_be), .mem_wdata(b_mem_wdata),
        .mem_ack(b_mem_ack), .mem_rdata(b_mem_rdata)
    );

    // Bus models: when enabled, complete every request in its first cycle.
    always @(negedge clk) begin
        a_auto_ack <= a_auto & a_mem_req;
        b_auto_ack <= b_auto & b_mem_req;
    end

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t sb_q[$];     // expected responses
    bit    gq[$];       // expected grant order, 1 = LSU

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction on instance A with full response and bus-field checks.
    task automatic a_txn(input string tag, input bit is_lsu, input logic wr,
                         input logic [2:0] func, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] bus_rdata,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input int exp_req_cyc, input logic [3:0] exp_be,
                         input logic [31:0] exp_maddr, input logic [31:0] exp_mwdata,
                         input int exp_lat);
        resp_t       e;
        resp_t       got;
        int          req_cyc;
        int          lat;
        bit          done;
        bit          other;
        logic        wr_c;
        logic [3:0]  be_c;
        logic [31:0] ad_c;
        logic [31:0] wd_c;
        @(negedge clk);
        a_mem_rdata = bus_rdata;
        if (is_lsu) begin
            a_lsu_wr    = wr;
            a_lsu_func  = func;
            a_lsu_addr  = addr;
            a_lsu_wdata = wdata;
            a_lsu_req   = 1'b1;
        end else begin
            a_if_addr = addr;
            a_if_req  = 1'b1;
        end
        e.rdata = exp_rdata;
        e.err   = exp_err;
        sb_q.push_back(e);
        req_cyc = 0; lat = 0; done = 1'b0; other = 1'b0;
        wr_c = 1'b0; be_c = 4'd0; ad_c = 32'd0; wd_c = 32'd0;
        for (int k = 1; k <= 20 && !done; k++) begin
            @(negedge clk);
            if (a_mem_req) begin
                if (req_cyc == 0) begin
                    wr_c = a_mem_wr; be_c = a_mem_be; ad_c = a_mem_addr; wd_c = a_mem_wdata;
                end
                req_cyc++;
            end
            if (is_lsu ? a_if_ack : a_lsu_ack) other = 1'b1;
            if (is_lsu ? a_lsu_ack : a_if_ack) begin
                done      = 1'b1;
                lat       = k;
                a_if_req  = 1'b0;
                a_lsu_req = 1'b0;
                got.rdata = is_lsu ? a_lsu_rdata : a_if_rdata;
                got.err   = is_lsu ? a_lsu_err : a_if_err;
                if (sb_q.size() > 0) e = sb_q.pop_front();
                chk({tag, "_rdata"}, got.rdata, e.rdata);
                chk({tag, "_err"}, {31'd0, got.err}, {31'd0, e.err});
            end
        end
        if (!done) begin
            a_if_req  = 1'b0;
            a_lsu_req = 1'b0;
            if (sb_q.size() > 0) e = sb_q.pop_front();
        end
        chk({tag, "_acked"}, {31'd0, done}, 32'd1);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_req_cycles"}, req_cyc, exp_req_cyc);
        chk({tag, "_wrong_ack"}, {31'd0, other}, 32'd0);
        if (exp_req_cyc > 0) begin
            chk({tag, "_mem_wr"}, {31'd0, wr_c}, {31'd0, is_lsu & wr});
            chk({tag, "_mem_be"}, {28'd0, be_c}, {28'd0, exp_be});
            chk({tag, "_mem_addr"}, ad_c, exp_maddr);
            chk({tag, "_mem_wdata"}, wd_c, exp_mwdata);
        end
        @(negedge clk);
        chk({tag, "_ack_pulse"}, {30'd0, a_if_ack, a_lsu_ack}, 32'd0);
    endtask

    // Both requesters pending continuously; LSU stops after n_both grants,
    // then one more grant is expected (for IF) before IF also stops.
    task automatic rr_run(input string tag, input bit inst, input int n_both);
        int acks;
        bit la;
        bit ia;
        bit e;
        @(negedge clk);
        if (inst) begin
            b_lsu_wr = 1'b0; b_lsu_func = 3'b010; b_lsu_addr = 32'h40;
            b_if_addr = 32'h80; b_if_req = 1'b1; b_lsu_req = 1'b1;
        end else begin
            a_lsu_wr = 1'b0; a_lsu_func = 3'b010; a_lsu_addr = 32'h40;
            a_if_addr = 32'h80; a_if_req = 1'b1; a_lsu_req = 1'b1;
        end
        acks = 0;
        for (int k = 0; k < 200 && acks < n_both + 1; k++) begin
            @(negedge clk);
            la = inst ? b_lsu_ack : a_lsu_ack;
            ia = inst ? b_if_ack : a_if_ack;
            if (la || ia) begin
                acks++;
                e = 1'b0;
                if (gq.size() > 0) e = gq.pop_front();
                chk($sformatf("%s_grant%0d", tag, acks), {31'd0, la}, {31'd0, e});
                if (acks == n_both) begin
                    if (inst) b_lsu_req = 1'b0; else a_lsu_req = 1'b0;
                end
                if (acks == n_both + 1) begin
                    if (inst) b_if_req = 1'b0; else a_if_req = 1'b0;
                end
            end
        end
        chk({tag, "_grant_count"}, acks, n_both + 1);
        a_if_req = 1'b0; a_lsu_req = 1'b0; b_if_req = 1'b0; b_lsu_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0;
        a_if_req = 1'b0; a_if_addr = 32'd0; a_lsu_req = 1'b0; a_lsu_wr = 1'b0;
        a_lsu_func = 3'd0; a_lsu_addr = 32'd0; a_lsu_wdata = 32'd0; a_mem_rdata = 32'd0;
        b_if_req = 1'b0; b_if_addr = 32'd0; b_lsu_req = 1'b0; b_lsu_wr = 1'b0;
        b_lsu_func = 3'd0; b_lsu_addr = 32'd0; b_lsu_wdata = 32'd0;
        b_mem_rdata = 32'h1111_1111;
        repeat (3) @(negedge clk);
        chk("rst_a_ctl", {26'd0, a_mem_req, a_if_ack, a_lsu_ack, a_if_err, a_lsu_err, a_mem_wr}, 32'd0);
        chk("rst_a_data", a_mem_addr | a_mem_wdata | a_if_rdata | a_lsu_rdata | {28'd0, a_mem_be}, 32'd0);
        chk("rst_b_ctl", {26'd0, b_mem_req, b_if_ack, b_lsu_ack, b_if_err, b_lsu_err, b_mem_wr}, 32'd0);
        chk("rst_b_data", b_mem_addr | b_mem_wdata | b_if_rdata | b_lsu_rdata | {28'd0, b_mem_be}, 32'd0);
        rst_n  = 1'b1;
        a_auto = 1'b1;
        b_auto = 1'b1;

        // Loads, stores and fetches with good alignment
        a_txn("lb_1003", 1'b1, 1'b0, 3'b000, 32'h1003, 32'd0, 32'h80FF_FF7F, 32'hFFFF_FF80, 1'b0,
              1, 4'b1000, 32'h1000, 32'd0, 2);
        a_txn("sh_2002", 1'b1, 1'b1, 3'b001, 32'h2002, 32'h1234_ABCD, 32'h5555_5555, 32'd0, 1'b0,
              1, 4'b1100, 32'h2000, 32'hABCD_ABCD, 2);
        a_txn("lhu_2002", 1'b1, 1'b0, 3'b101, 32'h2002, 32'd0, 32'hABCD_0000, 32'h0000_ABCD, 1'b0,
              1, 4'b1100, 32'h2000, 32'd0, 2);
        a_txn("sb_1001", 1'b1, 1'b1, 3'b000, 32'h1001, 32'h0000_0055, 32'd0, 32'd0, 1'b0,
              1, 4'b0010, 32'h1000, 32'h5555_5555, 2);
        a_txn("lh_0102", 1'b1, 1'b0, 3'b001, 32'h0102, 32'd0, 32'h8001_0000, 32'hFFFF_8001, 1'b0,
              1, 4'b1100, 32'h0100, 32'd0, 2);
        a_txn("lbu_0101", 1'b1, 1'b0, 3'b100, 32'h0101, 32'd0, 32'h0000_F000, 32'h0000_00F0, 1'b0,
              1, 4'b0010, 32'h0100, 32'd0, 2);
        a_txn("lw_0010", 1'b1, 1'b0, 3'b010, 32'h0010, 32'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0,
              1, 4'b1111, 32'h0010, 32'd0, 2);
        a_txn("sw_0024", 1'b1, 1'b1, 3'b010, 32'h0024, 32'h89AB_CDEF, 32'h0, 32'd0, 1'b0,
              1, 4'b1111, 32'h0024, 32'h89AB_CDEF, 2);
        a_txn("if_0100", 1'b0, 1'b0, 3'b000, 32'h0100, 32'd0, 32'h0000_0013, 32'h0000_0013, 1'b0,
              1, 4'b1111, 32'h0100, 32'd0, 2);

        // Rejected without a bus cycle: ack with err one cycle after request
        a_txn("lw_mis", 1'b1, 1'b0, 3'b010, 32'h3001, 32'd0, 32'h7777_7777, 32'd0, 1'b1,
              0, 4'd0, 32'd0, 32'd0, 1);
        a_txn("func011", 1'b1, 1'b0, 3'b011, 32'h3000, 32'd0, 32'h7777_7777, 32'd0, 1'b1,
              0, 4'd0, 32'd0, 32'd0, 1);
        a_txn("if_mis", 1'b0, 1'b0, 3'b000, 32'h0102, 32'd0, 32'h7777_7777, 32'd0, 1'b1,
              0, 4'd0, 32'd0, 32'd0, 1);
        a_txn("st_func100", 1'b1, 1'b1, 3'b100, 32'h0000, 32'h1, 32'd0, 32'd0, 1'b1,
              0, 4'd0, 32'd0, 32'd0, 1);
        a_txn("sh_mis", 1'b1, 1'b1, 3'b001, 32'h0001, 32'h1, 32'd0, 32'd0, 1'b1,
              0, 4'd0, 32'd0, 32'd0, 1);

        // Arbitration: fixed priority on A, round-robin on B
        gq.push_back(1'b1); gq.push_back(1'b1); gq.push_back(1'b1); gq.push_back(1'b0);
        rr_run("prio_fixed", 1'b0, 3);
        gq.push_back(1'b1); gq.push_back(1'b0); gq.push_back(1'b1); gq.push_back(1'b0);
        gq.push_back(1'b0);
        rr_run("prio_rr", 1'b1, 4);

        // Timeout: bus never answers, request held 4 cycles then error
        a_auto = 1'b0;
        a_txn("timeout", 1'b0, 1'b0, 3'b000, 32'h0200, 32'd0, 32'h0, 32'd0, 1'b1,
              4, 4'b1111, 32'h0200, 32'd0, 5);
        a_late_ack = 1'b1;
        @(negedge clk);
        a_late_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("late_ack_ignored", {29'd0, a_mem_req, a_if_ack, a_lsu_ack}, 32'd0);
        end

        // Reset while a bus cycle is outstanding
        a_if_addr = 32'h0300;
        a_if_req  = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 5 && !seen; k++) begin
            @(negedge clk);
            seen = a_mem_req;
        end
        chk("rst_busy_seen", {31'd0, seen}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_req", {29'd0, a_mem_req, a_if_ack, a_lsu_ack}, 32'd0);
        a_if_req = 1'b0;
        rst_n    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_no_ack", {29'd0, a_mem_req, a_if_ack, a_lsu_ack}, 32'd0);
        end
        a_auto = 1'b1;
        a_txn("if_after_rst", 1'b0, 1'b0, 3'b000, 32'h0304, 32'd0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0,
              1, 4'b1111, 32'h0304, 32'd0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32_mod_mem_port_arbiter.md
Name: rv32_mod_mem_port_arbiter

Overview:
- Shares the single core memory port between instruction fetch (IF) and the load/store path (LSU), which is driven by the decoder's ram_req/ram_wr fields.
- Arbitrates the two requesters and sequences one bus transaction at a time with a req/ack handshake.
- Generates byte enables and write-data lane replication, and extracts and sign- or zero-extends load data.
- Reports misaligned accesses, illegal widths and bus timeouts as errors.

Parameters:
- PRIO_MODE, 0, 0 = fixed LSU priority; 1 = round-robin between IF and LSU.
- TIMEOUT_CYCLES, 0, mem_ack wait limit in cycles; 0 disables the timeout.

Ports:
- clk  input  1  clock; all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- if_req  input  1  fetch request; held until if_ack
- if_addr  input  32  fetch address
- if_ack  output  1  one-cycle pulse: fetch done
- if_rdata  output  32  fetched word; valid with if_ack
- if_err  output  1  valid with if_ack: misaligned or timeout
- lsu_req  input  1  data request; held until lsu_ack
- lsu_wr  input  1  1 = store, 0 = load
- lsu_func  input  3  funct3 (width and signedness)
- lsu_addr  input  32  byte address
- lsu_wdata  input  32  store data, right-aligned
- lsu_ack  output  1  one-cycle pulse: data access done
- lsu_rdata  output  32  extended load data; valid with lsu_ack
- lsu_err  output  1  valid with lsu_ack
- mem_req  output  1  bus request, registered
- mem_wr  output  1  bus write
- mem_addr  output  32  word address, bits [1:0] = 00
- mem_be  output  4  byte enables
- mem_wdata  output  32  lane-replicated store data
- mem_ack  input  1  bus completion; single-cycle
- mem_rdata  input  32  read data; valid with mem_ack

Behaviour:
- Synchronous active-low reset, one clock. On reset every output is 0, state goes to IDLE, the round-robin pointer goes to "last = IF", and the timeout counter clears.
- Reset mid-transaction abandons it: mem_req drops next cycle and no ack is issued.
- FSM states are IDLE, BUS, RESP.
- IDLE:
  - Samples if_req and lsu_req.
  - If both are pending, PRIO_MODE 0 grants LSU. PRIO_MODE 1 grants the requester not granted last.
  - The granted request's fields are latched.
  - If the check fails, go to RESP with err = 1 and no bus cycle. Otherwise go to BUS.
- Check rules:
  - IF: if_addr[1:0] must be 00.
  - LSU: misaligned is LH/LHU/SH with addr[0] = 1, or LW/SW with addr[1:0] != 0.
  - LSU: illegal is lsu_func 011, 110, 111, or a store with lsu_func[2] = 1.
- BUS:
  - mem_req = 1 with stable mem_wr, mem_addr, mem_be and mem_wdata until mem_ack is sampled.
  - On mem_ack, capture the formatted read data and go to RESP.
  - The timeout counter increments each BUS cycle without mem_ack. When it reaches TIMEOUT_CYCLES (if nonzero), drop mem_req, set err = 1 and go to RESP.
  - mem_ack outside BUS is ignored.
- RESP:
  - The granted requester's ack pulses for exactly one cycle, with rdata and err.
  - The round-robin pointer updates and the FSM returns to IDLE.
  - Requests are not sampled in RESP. The requester must deassert or present a new request by the next cycle.
- Latency: request in IDLE at cycle 0 → mem_req at cycle 1 → mem_ack at cycle 1 at the earliest → ack at cycle 2. Minimum 3 cycles per transaction.
- Requester deassertion after grant is ignored; the transaction completes and is acked.
- Byte enables (o = addr[1:0]):
  - Byte: 0001 << o.
  - Half: 0011 << o.
  - Word: 1111.
  - Fetch: 1111.
- Store data:
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW: wdata.
- Load data: shift mem_rdata right by 8·o, then apply the width rule.
  - LB: sign-extend from bit 7.
  - LBU: zero-extend from bit 7.
  - LH: sign-extend from bit 15.
  - LHU: zero-extend from bit 15.
  - LW: unchanged.
- A store ack returns lsu_rdata = 0. An error ack returns rdata = 0.

Test Plan:
1. Load at lsu_addr = 0x1003, lsu_func = 000, mem_rdata = 0x80FF_FF7F, ack at cycle 1 → mem_be = 1000, mem_addr = 0x1000, lsu_rdata = 0xFFFF_FF80, lsu_ack at cycle 2.
2. Store SH at 0x2002, wdata = 0x1234_ABCD → mem_be = 1100, mem_wdata = 0xABCD_ABCD, mem_wr = 1; LHU at 0x2002 with mem_rdata = 0xABCD_0000 → lsu_rdata = 0x0000_ABCD.
3. LW at 0x3001 → no mem_req; lsu_ack with lsu_err = 1 at cycle 1. lsu_func = 011 gives the same response.
4. if_req and lsu_req asserted together, both re-requesting continuously: PRIO_MODE 0 → grants LSU, LSU, LSU… and IF is served only when LSU is idle. PRIO_MODE 1 → LSU, IF, LSU, IF.
5. TIMEOUT_CYCLES = 4, mem_ack never asserted → mem_req high for 4 cycles, then if_ack with if_err = 1. A late mem_ack after that is ignored.
6. rst_n low while in BUS → next cycle mem_req = 0, no ack. After release, a fresh fetch completes normally.
